// File: rtl/dispatch_unit_rename_if.sv
// Dispatch unit bus: instruction slots from the fetch queue, dispatch strobes
// toward the reservation stations, CDB completion and register busy status.
//   master: fetch-queue / CDB side (drives instructions and completions)
//   slave : dispatch unit (drives fetch acks, dispatch fields, status)
interface dispatch_unit_rename_if #(
  parameter int NUM_REG      = 4,
  parameter int INS_PART_WID = 4,
  parameter int TAG_LEN      = 4
);
  logic                    inst_1_valid;
  logic [INS_PART_WID-1:0] inst_1_type;
  logic [INS_PART_WID-1:0] inst_1_dest;
  logic [INS_PART_WID-1:0] inst_1_src0;
  logic [INS_PART_WID-1:0] inst_1_src1;
  logic                    inst_1_fetch;
  logic                    inst_2_valid;
  logic [INS_PART_WID-1:0] inst_2_type;
  logic [INS_PART_WID-1:0] inst_2_dest;
  logic [INS_PART_WID-1:0] inst_2_src0;
  logic [INS_PART_WID-1:0] inst_2_src1;
  logic                    inst_2_fetch;
  logic                    disp1_valid;
  logic [TAG_LEN-1:0]      disp1_rs;
  logic [TAG_LEN-1:0]      disp1_q0;
  logic [TAG_LEN-1:0]      disp1_q1;
  logic [INS_PART_WID-1:0] disp1_src0;
  logic [INS_PART_WID-1:0] disp1_src1;
  logic                    disp2_valid;
  logic [TAG_LEN-1:0]      disp2_rs;
  logic [TAG_LEN-1:0]      disp2_q0;
  logic [TAG_LEN-1:0]      disp2_q1;
  logic [INS_PART_WID-1:0] disp2_src0;
  logic [INS_PART_WID-1:0] disp2_src1;
  logic                    cdb_valid;
  logic [TAG_LEN-1:0]      cdb_tag;
  logic [NUM_REG-1:0]      reg_busy;
  logic                    illegal_inst;

  modport master (
    output inst_1_valid, inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1,
    output inst_2_valid, inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1,
    output cdb_valid, cdb_tag,
    input  inst_1_fetch, inst_2_fetch,
    input  disp1_valid, disp1_rs, disp1_q0, disp1_q1, disp1_src0, disp1_src1,
    input  disp2_valid, disp2_rs, disp2_q0, disp2_q1, disp2_src0, disp2_src1,
    input  reg_busy, illegal_inst
  );

  modport slave (
    input  inst_1_valid, inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1,
    input  inst_2_valid, inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1,
    input  cdb_valid, cdb_tag,
    output inst_1_fetch, inst_2_fetch,
    output disp1_valid, disp1_rs, disp1_q0, disp1_q1, disp1_src0, disp1_src1,
    output disp2_valid, disp2_rs, disp2_q0, disp2_q1, disp2_src0, disp2_src1,
    output reg_busy, illegal_inst
  );
endinterface

// File: rtl/dispatch_unit_rename.sv
// Dual-issue in-order dispatch with register renaming.
// Allocates the lowest free reservation station of each instruction's class
// (ADD/MULT/FETCH/STORE), tags sources with their producing RS from the
// register status table, and retires busy state on CDB completion.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : dispatch_unit_rename_if.slave (slots, dispatch, CDB, status)
module dispatch_unit_rename #(
  parameter int NUM_REG      = 4,
  parameter int RS_PER_CLASS = 2,
  parameter int INS_PART_WID = 4,
  parameter int TAG_LEN      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  dispatch_unit_rename_if.slave  bus
);

  localparam int         NRS       = 4 * RS_PER_CLASS;
  localparam logic [1:0] CLS_STORE = 2'd3;

  logic [NRS-1:0]     rs_busy;
  logic [TAG_LEN-1:0] tbl_tag [NUM_REG];
  logic [NUM_REG-1:0] tbl_busy;

  logic               cdb_hit;
  logic [NRS-1:0]     cdb_clr;
  logic               legal1, legal2, found1, found2;
  logic               acc1, acc2, take1, take2, wr1, wr2;
  logic [1:0]         cls1, cls2;
  logic [TAG_LEN-1:0] tag1, tag2;
  logic [NRS-1:0]     alloc1, alloc2, avail2;
  logic [TAG_LEN-1:0] q1_0, q1_1, q2_0, q2_1;

  logic                    disp1_vld_p1, disp2_vld_p1, illegal_vld_p1;
  logic [TAG_LEN-1:0]      disp1_rs_p1, disp1_q0_p1, disp1_q1_p1;
  logic [TAG_LEN-1:0]      disp2_rs_p1, disp2_q0_p1, disp2_q1_p1;
  logic [INS_PART_WID-1:0] disp1_src0_p1, disp1_src1_p1;
  logic [INS_PART_WID-1:0] disp2_src0_p1, disp2_src1_p1;

  function automatic logic is_legal(input logic [INS_PART_WID-1:0] t);
    return (t != '0) && (t <= INS_PART_WID'(4));
  endfunction

  function automatic logic [1:0] type_cls(input logic [INS_PART_WID-1:0] t);
    logic [INS_PART_WID-1:0] m;
    m = t - 1'b1;
    return m[1:0];
  endfunction

  function automatic logic [TAG_LEN-1:0] rs_tag(input int i);
    return TAG_LEN'(i + 1);
  endfunction

  // Producer tag for a source, with completing-tag bypass applied.
  function automatic logic [TAG_LEN-1:0] src_tag(
    input logic [INS_PART_WID-1:0] src,
    input logic                    hit,
    input logic [TAG_LEN-1:0]      ctag
  );
    logic [TAG_LEN-1:0] t;
    t = '0;
    for (int r = 0; r < NUM_REG; r++)
      if (src == INS_PART_WID'(r)) t = tbl_tag[r];
    if (hit && t == ctag) t = '0;
    return t;
  endfunction

  // Stage 0: allocation, acceptance and source tag lookup
  always_comb begin
    cdb_hit = 1'b0;
    cdb_clr = '0;
    for (int i = 0; i < NRS; i++)
      if (bus.cdb_valid && rs_busy[i] && bus.cdb_tag == rs_tag(i)) begin
        cdb_hit    = 1'b1;
        cdb_clr[i] = 1'b1;
      end

    legal1 = is_legal(bus.inst_1_type);
    cls1   = type_cls(bus.inst_1_type);
    found1 = 1'b0;
    tag1   = '0;
    alloc1 = '0;
    for (int k = 0; k < RS_PER_CLASS; k++)
      if (!found1 && !rs_busy[int'(cls1) * RS_PER_CLASS + k]) begin
        found1 = 1'b1;
        tag1   = rs_tag(int'(cls1) * RS_PER_CLASS + k);
        alloc1 = NRS'(1) << (int'(cls1) * RS_PER_CLASS + k);
      end
    acc1  = !rst && bus.inst_1_valid && (!legal1 || found1);
    take1 = acc1 && legal1;
    wr1   = take1 && (cls1 != CLS_STORE);

    // Slot 2 sees slot 1's allocation so same-class pairs get distinct RSs.
    avail2 = ~rs_busy & ~(take1 ? alloc1 : '0);
    legal2 = is_legal(bus.inst_2_type);
    cls2   = type_cls(bus.inst_2_type);
    found2 = 1'b0;
    tag2   = '0;
    alloc2 = '0;
    for (int k = 0; k < RS_PER_CLASS; k++)
      if (!found2 && avail2[int'(cls2) * RS_PER_CLASS + k]) begin
        found2 = 1'b1;
        tag2   = rs_tag(int'(cls2) * RS_PER_CLASS + k);
        alloc2 = NRS'(1) << (int'(cls2) * RS_PER_CLASS + k);
      end
    acc2  = acc1 && bus.inst_2_valid && (!legal2 || found2);
    take2 = acc2 && legal2;
    wr2   = take2 && (cls2 != CLS_STORE);

    q1_0 = src_tag(bus.inst_1_src0, cdb_hit, bus.cdb_tag);
    q1_1 = src_tag(bus.inst_1_src1, cdb_hit, bus.cdb_tag);
    // Slot-1 result feeds slot 2 directly; overrides table and bypass.
    q2_0 = (wr1 && bus.inst_2_src0 == bus.inst_1_dest) ? tag1
         : src_tag(bus.inst_2_src0, cdb_hit, bus.cdb_tag);
    q2_1 = (wr1 && bus.inst_2_src1 == bus.inst_1_dest) ? tag1
         : src_tag(bus.inst_2_src1, cdb_hit, bus.cdb_tag);
  end

  assign bus.inst_1_fetch = acc1;
  assign bus.inst_2_fetch = acc2;

  // Stage 1: state update and registered dispatch outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rs_busy        <= '0;
      tbl_busy       <= '0;
      for (int r = 0; r < NUM_REG; r++) tbl_tag[r] <= '0;
      disp1_vld_p1   <= 1'b0;
      disp2_vld_p1   <= 1'b0;
      illegal_vld_p1 <= 1'b0;
      disp1_rs_p1    <= '0;
      disp1_q0_p1    <= '0;
      disp1_q1_p1    <= '0;
      disp1_src0_p1  <= '0;
      disp1_src1_p1  <= '0;
      disp2_rs_p1    <= '0;
      disp2_q0_p1    <= '0;
      disp2_q1_p1    <= '0;
      disp2_src0_p1  <= '0;
      disp2_src1_p1  <= '0;
    end else begin
      rs_busy <= (rs_busy & ~cdb_clr) | (take1 ? alloc1 : '0) | (take2 ? alloc2 : '0);
      // Rename beats completion; slot 2 beats slot 1 on WAW.
      for (int r = 0; r < NUM_REG; r++) begin
        if (wr2 && bus.inst_2_dest == INS_PART_WID'(r)) begin
          tbl_tag[r]  <= tag2;
          tbl_busy[r] <= 1'b1;
        end else if (wr1 && bus.inst_1_dest == INS_PART_WID'(r)) begin
          tbl_tag[r]  <= tag1;
          tbl_busy[r] <= 1'b1;
        end else if (cdb_hit && tbl_busy[r] && tbl_tag[r] == bus.cdb_tag) begin
          tbl_tag[r]  <= '0;
          tbl_busy[r] <= 1'b0;
        end
      end
      disp1_vld_p1   <= take1;
      disp2_vld_p1   <= take2;
      illegal_vld_p1 <= (acc1 && !legal1) || (acc2 && !legal2);
      disp1_rs_p1    <= tag1;
      disp1_q0_p1    <= q1_0;
      disp1_q1_p1    <= q1_1;
      disp1_src0_p1  <= bus.inst_1_src0;
      disp1_src1_p1  <= bus.inst_1_src1;
      disp2_rs_p1    <= tag2;
      disp2_q0_p1    <= q2_0;
      disp2_q1_p1    <= q2_1;
      disp2_src0_p1  <= bus.inst_2_src0;
      disp2_src1_p1  <= bus.inst_2_src1;
    end
  end

  assign bus.disp1_valid  = disp1_vld_p1;
  assign bus.disp1_rs     = disp1_rs_p1;
  assign bus.disp1_q0     = disp1_q0_p1;
  assign bus.disp1_q1     = disp1_q1_p1;
  assign bus.disp1_src0   = disp1_src0_p1;
  assign bus.disp1_src1   = disp1_src1_p1;
  assign bus.disp2_valid  = disp2_vld_p1;
  assign bus.disp2_rs     = disp2_rs_p1;
  assign bus.disp2_q0     = disp2_q0_p1;
  assign bus.disp2_q1     = disp2_q1_p1;
  assign bus.disp2_src0   = disp2_src0_p1;
  assign bus.disp2_src1   = disp2_src1_p1;
  assign bus.reg_busy     = tbl_busy;
  assign bus.illegal_inst = illegal_vld_p1;

endmodule

// File: tb/tb_dispatch_unit_rename.sv
// Directed bench for dispatch_unit_rename with a behavioural rename model.
module tb_dispatch_unit_rename;
  localparam int NUM_REG = 4;
  localparam int RSP     = 2;
  localparam int IW      = 4;
  localparam int TL      = 4;
  localparam int NTAG    = 4 * RSP;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_unit_rename_if #(.NUM_REG(NUM_REG), .INS_PART_WID(IW), .TAG_LEN(TL)) bus ();

  dispatch_unit_rename #(
    .NUM_REG(NUM_REG), .RS_PER_CLASS(RSP), .INS_PART_WID(IW), .TAG_LEN(TL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: producer tag per register (0 = ready), busy flag per RS tag.
  int m_tag [NUM_REG];
  bit m_rs  [NTAG+1];

  int e_f1, e_f2, e_d1v, e_d2v, e_ill, e_busy;
  int e_d1rs, e_d1q0, e_d1q1, e_d1s0, e_d1s1;
  int e_d2rs, e_d2q0, e_d2q1, e_d2s0, e_d2s1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_free(input int cls, input int excl);
    for (int k = 0; k < RSP; k++) begin
      int t;
      t = cls * RSP + k + 1;
      if (!m_rs[t] && t != excl) return t;
    end
    return 0;
  endfunction

  function automatic int read_q(input int src, input bit ok, input int ct);
    if (src >= NUM_REG) return 0;
    if (ok && m_tag[src] == ct) return 0;
    return m_tag[src];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_REG; r++) m_tag[r] = 0;
    for (int t = 0; t <= NTAG; t++) m_rs[t] = 0;
  endtask

  task automatic set1(input bit v, input int ty, input int d, input int a, input int b);
    bus.inst_1_valid = v;
    bus.inst_1_type  = IW'(ty);
    bus.inst_1_dest  = IW'(d);
    bus.inst_1_src0  = IW'(a);
    bus.inst_1_src1  = IW'(b);
  endtask

  task automatic set2(input bit v, input int ty, input int d, input int a, input int b);
    bus.inst_2_valid = v;
    bus.inst_2_type  = IW'(ty);
    bus.inst_2_dest  = IW'(d);
    bus.inst_2_src0  = IW'(a);
    bus.inst_2_src1  = IW'(b);
  endtask

  task automatic set_cdb(input bit v, input int t);
    bus.cdb_valid = v;
    bus.cdb_tag   = TL'(t);
  endtask

  task automatic idle();
    set1(0, 0, 0, 0, 0);
    set2(0, 0, 0, 0, 0);
    set_cdb(0, 0);
  endtask

  // One clock: predict, check fetch, advance, check registered outputs.
  task automatic cycle();
    int ty1, ty2, c1, c2, d1, d2, t1, t2, ct;
    bit l1, l2, a1, a2, w1, w2, ok;
    #1;
    if (rst) begin
      model_reset();
      e_f1 = 0; e_f2 = 0; e_d1v = 0; e_d2v = 0; e_ill = 0;
    end else begin
      ty1 = int'(bus.inst_1_type);  ty2 = int'(bus.inst_2_type);
      d1  = int'(bus.inst_1_dest);  d2  = int'(bus.inst_2_dest);
      ct  = int'(bus.cdb_tag);
      l1 = (ty1 >= 1 && ty1 <= 4);  c1 = ty1 - 1;
      l2 = (ty2 >= 1 && ty2 <= 4);  c2 = ty2 - 1;
      t1 = l1 ? first_free(c1, 0) : 0;
      a1 = bus.inst_1_valid && (!l1 || t1 != 0);
      w1 = a1 && l1 && c1 != 3;
      t2 = l2 ? first_free(c2, (a1 && l1) ? t1 : 0) : 0;
      a2 = a1 && bus.inst_2_valid && (!l2 || t2 != 0);
      w2 = a2 && l2 && c2 != 3;
      ok = bus.cdb_valid && ct >= 1 && ct <= NTAG && m_rs[ct];
      e_f1 = a1; e_f2 = a2;
      e_d1v = a1 && l1; e_d2v = a2 && l2;
      e_ill = (a1 && !l1) || (a2 && !l2);
      e_d1rs = t1; e_d2rs = t2;
      e_d1s0 = int'(bus.inst_1_src0); e_d1s1 = int'(bus.inst_1_src1);
      e_d2s0 = int'(bus.inst_2_src0); e_d2s1 = int'(bus.inst_2_src1);
      e_d1q0 = read_q(e_d1s0, ok, ct);
      e_d1q1 = read_q(e_d1s1, ok, ct);
      e_d2q0 = (w1 && e_d2s0 == d1) ? t1 : read_q(e_d2s0, ok, ct);
      e_d2q1 = (w1 && e_d2s1 == d1) ? t1 : read_q(e_d2s1, ok, ct);
      if (ok) begin
        m_rs[ct] = 0;
        for (int r = 0; r < NUM_REG; r++) if (m_tag[r] == ct) m_tag[r] = 0;
      end
      if (a1 && l1) m_rs[t1] = 1;
      if (a2 && l2) m_rs[t2] = 1;
      if (w1 && d1 < NUM_REG) m_tag[d1] = t1;
      if (w2 && d2 < NUM_REG) m_tag[d2] = t2;
    end
    e_busy = 0;
    for (int r = 0; r < NUM_REG; r++) if (m_tag[r] != 0) e_busy |= (1 << r);
    chk("inst_1_fetch", int'(bus.inst_1_fetch), e_f1);
    chk("inst_2_fetch", int'(bus.inst_2_fetch), e_f2);
    @(posedge clk);
    #1;
    chk("reg_busy", int'(bus.reg_busy), e_busy);
    chk("disp1_valid", int'(bus.disp1_valid), e_d1v);
    chk("disp2_valid", int'(bus.disp2_valid), e_d2v);
    chk("illegal_inst", int'(bus.illegal_inst), e_ill);
    if (e_d1v != 0) begin
      chk("disp1_rs", int'(bus.disp1_rs), e_d1rs);
      chk("disp1_q0", int'(bus.disp1_q0), e_d1q0);
      chk("disp1_q1", int'(bus.disp1_q1), e_d1q1);
      chk("disp1_src0", int'(bus.disp1_src0), e_d1s0);
      chk("disp1_src1", int'(bus.disp1_src1), e_d1s1);
    end
    if (e_d2v != 0) begin
      chk("disp2_rs", int'(bus.disp2_rs), e_d2rs);
      chk("disp2_q0", int'(bus.disp2_q0), e_d2q0);
      chk("disp2_q1", int'(bus.disp2_q1), e_d2q1);
      chk("disp2_src0", int'(bus.disp2_src0), e_d2s0);
      chk("disp2_src1", int'(bus.disp2_src1), e_d2s1);
    end
    @(negedge clk);
  endtask

  task automatic cdb_only(input int t);
    idle();
    set_cdb(1, t);
    cycle();
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    idle();
    set1(1, 1, 1, 0, 0);
    @(negedge clk);
    cycle();
    cycle();
    chk("lit_reset_busy", int'(bus.reg_busy), 0);
    chk("lit_reset_disp1", int'(bus.disp1_valid), 0);
    rst = 1'b0;
    idle();
    cycle();

    // ADD r1<-r2,r3 with MULT r2<-r1,r0: intra-group RAW
    set1(1, 1, 1, 2, 3);
    set2(1, 2, 2, 1, 0);
    cycle();
    chk("lit_t1_disp1_rs", int'(bus.disp1_rs), 1);
    chk("lit_t1_disp1_q0", int'(bus.disp1_q0), 0);
    chk("lit_t1_disp2_rs", int'(bus.disp2_rs), 3);
    chk("lit_t1_disp2_q0", int'(bus.disp2_q0), 1);
    chk("lit_t1_busy", int'(bus.reg_busy), 6);
    cdb_only(1);
    cdb_only(3);

    // Three ADDs: third stalls until RS 1 completes
    idle(); set1(1, 1, 0, 1, 1); cycle();
    idle(); set1(1, 1, 1, 0, 0); cycle();
    idle(); set1(1, 1, 2, 3, 3); #1;
    chk("lit_t2_stall", int'(bus.inst_1_fetch), 0);
    cycle();
    set_cdb(1, 1); cycle();
    set_cdb(0, 0); cycle();
    chk("lit_t2_disp1_rs", int'(bus.disp1_rs), 1);
    cdb_only(2);
    cdb_only(1);

    // Both STORE RSs taken, then STORE + ADD blocked in order
    idle(); set1(1, 4, 0, 0, 1); set2(1, 4, 0, 2, 3); cycle();
    idle(); set1(1, 4, 0, 0, 0); set2(1, 1, 1, 0, 0); #1;
    chk("lit_t3_fetch1", int'(bus.inst_1_fetch), 0);
    chk("lit_t3_fetch2", int'(bus.inst_2_fetch), 0);
    cycle();
    cdb_only(7);
    cdb_only(8);

    // CDB bypass on the renamed source
    idle(); set1(1, 3, 3, 0, 0); cycle();
    idle(); set1(1, 1, 0, 3, 3); set_cdb(1, 5); cycle();
    chk("lit_t4_q0", int'(bus.disp1_q0), 0);
    chk("lit_t4_q1", int'(bus.disp1_q1), 0);
    chk("lit_t4_busy", int'(bus.reg_busy), 1);
    cdb_only(1);

    // WAW: FETCH r2 then ADD r2, CDB of the overwritten tag
    idle(); set1(1, 3, 2, 0, 0); set2(1, 1, 2, 0, 0); cycle();
    cdb_only(5);
    chk("lit_t5_busy", int'(bus.reg_busy), 4);
    cdb_only(1);

    // Illegal type consumed without dispatch
    idle(); set1(1, 9, 1, 0, 0); #1;
    chk("lit_t6_fetch", int'(bus.inst_1_fetch), 1);
    cycle();
    chk("lit_t6_illegal", int'(bus.illegal_inst), 1);
    chk("lit_t6_disp1", int'(bus.disp1_valid), 0);
    chk("lit_t6_busy", int'(bus.reg_busy), 0);

    // Illegal slot 1 with legal slot 2; ignored CDB tags
    idle(); set1(1, 0, 2, 0, 0); set2(1, 1, 3, 1, 2); cycle();
    cdb_only(0);
    cdb_only(6);
    // Rename beats completion on the same register
    idle(); set1(1, 1, 3, 3, 0); set_cdb(1, 1); cycle();
    idle(); set1(1, 2, 0, 3, 1); set2(1, 2, 1, 0, 3); cycle();
    idle(); set1(1, 2, 2, 0, 1); cycle();
    cdb_only(2);
    cdb_only(3);
    cdb_only(4);

    // Reset in the middle of traffic discards that edge
    idle(); set1(1, 1, 0, 0, 0); set2(1, 1, 1, 0, 0); cycle();
    rst = 1'b1; set1(1, 2, 2, 0, 0); cycle();
    chk("lit_rst_busy", int'(bus.reg_busy), 0);
    rst = 1'b0; idle(); cycle();
    set1(1, 1, 3, 0, 0); cycle();
    chk("lit_post_rst_rs", int'(bus.disp1_rs), 1);
    idle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dispatch_unit_rename.md
Name: dispatch_unit_rename

Overview:
- Parametrised dual-issue, in-order instruction dispatch unit with register renaming via a register status table.
- Allocates reservation stations (RS) per class (ADD, MULT, FETCH, STORE) with a generic RS count per class.
- Tags each dispatched source with its producing RS and clears busy state on common-data-bus (CDB) completion.
- Sits between the instruction fetch queue and the reservation stations.

Parameters:
NUM_REG, 4, number of architectural registers (register index width = INS_PART_WID)
RS_PER_CLASS, 2, reservation stations per instruction class (4 classes)
INS_PART_WID, 4, bit width of each instruction field
TAG_LEN, 4, RS tag width; must hold 4*RS_PER_CLASS; tag 0 = "value ready / no producer"

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
inst_1_valid  in  1  slot-1 (older) instruction present
inst_1_type  in  INS_PART_WID  1=ADD, 2=MULT, 3=FETCH, 4=STORE, others illegal
inst_1_dest, inst_1_src0, inst_1_src1  in  INS_PART_WID each  register indices
inst_1_fetch  out  1  combinational; slot-1 consumed this cycle
inst_2_valid/type/dest/src0/src1  in  as slot 1  slot-2 (younger) instruction
inst_2_fetch  out  1  combinational; slot-2 consumed this cycle
disp1_valid, disp2_valid  out  1 each  registered dispatch strobe
disp1_rs, disp2_rs  out  TAG_LEN each  allocated RS tag
disp1_q0, disp1_q1, disp2_q0, disp2_q1  out  TAG_LEN each  source producer tag, 0 = ready
disp1_src0, disp1_src1, disp2_src0, disp2_src1  out  INS_PART_WID each  source register indices
cdb_valid  in  1  completion broadcast
cdb_tag  in  TAG_LEN  completing RS tag
reg_busy  out  NUM_REG  per-register busy bit
illegal_inst  out  1  registered; pulses one cycle per dropped illegal instruction

Behaviour:
- Reset: all RS free, every register status entry = {tag 0, not busy}, all disp*/illegal_inst outputs 0, reg_busy = 0.
- Tag map: tag = class*RS_PER_CLASS + idx + 1, with class ADD=0, MULT=1, FETCH=2, STORE=3.
  - Default tags: ADD 1-2, MULT 3-4, FETCH 5-6, STORE 7-8.
- Allocation: lowest-index free RS of the required class.
  - Slot 2 is evaluated after slot 1's allocation, so two same-class instructions receive distinct RSs.
- In-order rule: inst_2_fetch is asserted only when inst_1_fetch is asserted in the same cycle.
- Slot N is accepted when valid and one of the following holds:
  - a free RS of its class exists, or
  - its type is illegal. An illegal instruction is consumed, not dispatched, and illegal_inst pulses next cycle.
- Structural stall: no free RS means fetch = 0 and all state holds.
- Latency: acceptance in cycle T gives dispN_* valid in cycle T+1 for exactly one cycle; fields are don't-care when valid = 0.
- Source tags are read from the register status table at cycle T, with these overrides:
  - CDB bypass: if cdb_valid and the table tag equals cdb_tag, q = 0.
  - Intra-group RAW: if slot-2 src equals slot-1 dest and slot 1 writes a dest, slot-2 q = slot-1 RS tag. This has priority over the table and the bypass.
- Destination rename:
  - ADD, MULT and FETCH set table[dest] = {rs tag, busy}.
  - STORE writes no destination.
  - Same-cycle WAW (both slots write the same dest): slot 2's tag wins.
- CDB completion at cycle T:
  - The RS named by cdb_tag becomes free at T+1. It is not allocatable in cycle T itself.
  - Every register whose table tag equals cdb_tag is cleared at T+1, unless a dispatch in cycle T renames that register; the rename wins.
- A cdb_tag of 0, or a tag that is not busy, is ignored.
- reg_busy reflects the table state after the clock edge (registered).
- Reset asserted mid-operation: the state of the same edge is discarded, and the fetch outputs are 0 while rst = 1.

Test Plan:
- Reset, then slot1 ADD r1<-r2,r3 and slot2 MULT r2<-r1,r0 in the same cycle -> both fetch = 1. Next cycle:
  - disp1_rs = 1, disp1_q0 = disp1_q1 = 0.
  - disp2_rs = 3, disp2_q0 = 1 (intra-group RAW).
  - reg_busy = 4'b0110.
- Three consecutive ADDs with no CDB -> first two get tags 1 and 2. The third stalls (inst_1_fetch = 0) until cdb_valid with cdb_tag = 1; it dispatches with rs = 1 one cycle after that CDB cycle.
- Slot1 STORE blocked (both STORE RSs busy), slot2 ADD valid -> inst_1_fetch = 0 and inst_2_fetch = 0 (in-order).
- r3 renamed to tag 5, then in one cycle cdb_tag = 5 and ADD r0<-r3,r3 arrive -> disp1_q0 = disp1_q1 = 0 (bypass), and reg_busy[3] = 0 next cycle.
- Slot1 FETCH r2 and slot2 ADD r2 in one cycle, then CDB tag 5 -> table[r2] = tag 1, and r2 stays busy after the CDB of tag 5.
- inst_1_type = 4'b1001 -> inst_1_fetch = 1, illegal_inst = 1 next cycle, disp1_valid = 0, and no table change.
